// File: rtl/park_pkg.sv
// Shared definitions for the two-beam parking-gate sensor interface:
// FSM states, phase/direction codes and the beam pattern for each phase.
package park_pkg;

  typedef enum logic [2:0] {IDLE, P1, P2, P3, GAP} state_t;

  localparam logic [1:0] PH_IDLE   = 2'd0;
  localparam logic [1:0] PH_FIRST  = 2'd1;
  localparam logic [1:0] PH_BOTH   = 2'd2;
  localparam logic [1:0] PH_SECOND = 2'd3;

  localparam logic DIR_ENTER = 1'b0;
  localparam logic DIR_EXIT  = 1'b1;

  function automatic logic [1:0] phase_of(input state_t s);
    logic [1:0] ph;
    case (s)
      P1:      ph = PH_FIRST;
      P2:      ph = PH_BOTH;
      P3:      ph = PH_SECOND;
      default: ph = PH_IDLE;
    endcase
    return ph;
  endfunction

  // Returns {a,b}; consecutive phases differ in exactly one beam.
  function automatic logic [1:0] beam_pattern(input logic dir, input logic [1:0] ph);
    logic [1:0] ab;
    case (ph)
      PH_FIRST:  ab = (dir == DIR_EXIT) ? 2'b01 : 2'b10;
      PH_BOTH:   ab = 2'b11;
      PH_SECOND: ab = (dir == DIR_ENTER) ? 2'b01 : 2'b10;
      default:   ab = 2'b00;
    endcase
    return ab;
  endfunction

endpackage

// File: rtl/park_gate_driver_dwell_timer.sv
// Loadable down-counter timing each beam phase and the clear gap.
// Load takes priority over enable; the count holds at zero.
module dwell_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/park_gate_driver.sv
// Transmitter end of the two-beam gate interface: plays the beam sequence
// of a car entering or exiting and tracks the resulting net car count.
module park_gate_driver
  import park_pkg::*;
#(
  parameter int DWELL_W = 8,
  parameter int GAP_CYC = 2,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               dir,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               abort,
  output logic               ready,
  output logic               done,
  output logic               a,
  output logic               b,
  output logic [1:0]         phase,
  output logic [CNT_W-1:0]   net_count
);

  localparam logic [DWELL_W-1:0] GAP_LOAD = DWELL_W'(GAP_CYC - 1);

  state_t             state, next_state;
  logic               dir_q, dir_n;
  logic [DWELL_W-1:0] dmax_q, dmax_n;
  logic               aborted_q, aborted_n;
  logic               tmr_load, tmr_en, tmr_zero;
  logic [DWELL_W-1:0] tmr_val;
  logic               done_n;
  logic [CNT_W-1:0]   count_n;
  logic [1:0]         beams_n;

  dwell_timer #(.W(DWELL_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .en       (tmr_en),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  // Outputs are registered from the next-state values so they line up with the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      dir_q     <= DIR_ENTER;
      dmax_q    <= '0;
      aborted_q <= 1'b0;
      ready     <= 1'b1;
      done      <= 1'b0;
      a         <= 1'b0;
      b         <= 1'b0;
      phase     <= PH_IDLE;
      net_count <= '0;
    end else begin
      state     <= next_state;
      dir_q     <= dir_n;
      dmax_q    <= dmax_n;
      aborted_q <= aborted_n;
      ready     <= (next_state == IDLE);
      done      <= done_n;
      {a, b}    <= beams_n;
      phase     <= phase_of(next_state);
      net_count <= count_n;
    end
  end

  always_comb begin
    next_state = state;
    dir_n      = dir_q;
    dmax_n     = dmax_q;
    aborted_n  = aborted_q;
    tmr_load   = 1'b0;
    tmr_en     = 1'b0;
    tmr_val    = '0;
    done_n     = 1'b0;
    count_n    = net_count;

    case (state)
      IDLE: begin
        if (start) begin
          next_state = P1;
          dir_n      = dir;
          dmax_n     = (dwell == '0) ? '0 : dwell - 1'b1;
          aborted_n  = 1'b0;
          tmr_load   = 1'b1;
          tmr_val    = (dwell == '0) ? '0 : dwell - 1'b1;
        end
      end
      P1, P2, P3: begin
        if (abort) begin
          next_state = GAP;
          aborted_n  = 1'b1;
          tmr_load   = 1'b1;
          tmr_val    = GAP_LOAD;
        end else if (tmr_zero) begin
          tmr_load = 1'b1;
          if (state == P3) begin
            next_state = GAP;
            tmr_val    = GAP_LOAD;
          end else begin
            next_state = (state == P1) ? P2 : P3;
            tmr_val    = dmax_q;
          end
        end else begin
          tmr_en = 1'b1;
        end
      end
      GAP: begin
        if (tmr_zero) begin
          next_state = IDLE;
          if (!aborted_q) begin
            done_n  = 1'b1;
            count_n = (dir_q == DIR_ENTER) ? net_count + CNT_W'(1) : net_count - CNT_W'(1);
          end
        end else begin
          tmr_en = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase

    beams_n = beam_pattern(dir_n, phase_of(next_state));
  end

endmodule

// File: tb/tb_park_gate_driver.sv
// Scoreboard bench for park_gate_driver: the stimulus side predicts the whole
// per-cycle beam trace of each accepted car; a negedge monitor consumes it.
module tb_park_gate_driver;

  localparam int DWELL_W = 8;
  localparam int GAP_CYC = 2;
  localparam int CNT_W   = 32;

  logic               clk   = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic               dir   = 1'b0;
  logic [DWELL_W-1:0] dwell = '0;
  logic               abort = 1'b0;
  logic               ready, done, a, b;
  logic [1:0]         phase;
  logic [CNT_W-1:0]   net_count;

  park_gate_driver #(.DWELL_W(DWELL_W), .GAP_CYC(GAP_CYC), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dir       (dir),
    .dwell     (dwell),
    .abort     (abort),
    .ready     (ready),
    .done      (done),
    .a         (a),
    .b         (b),
    .phase     (phase),
    .net_count (net_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        a;
    logic        b;
    logic [1:0]  phase;
    logic        ready;
    logic        done;
    logic [31:0] count;
  } exp_t;

  exp_t        trace_q[$];
  logic [31:0] done_q[$];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] model_count = '0;
  logic [31:0] seq_base    = '0;
  logic [1:0]  cur_phase   = '0;
  bit          mon_en      = 1'b0;
  // Beams a car blocks while entering; an exit crosses the same beams in reverse.
  logic [1:0]  enter_seq [1:3] = '{2'b10, 2'b11, 2'b01};

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t mk(input logic [1:0] ab, input logic [1:0] ph, input logic rdy,
                              input logic dn, input logic [31:0] cnt);
    exp_t e;
    e.a = ab[1]; e.b = ab[0]; e.phase = ph; e.ready = rdy; e.done = dn; e.count = cnt;
    return e;
  endfunction

  function automatic void push_sequence(input logic d, input logic [7:0] dw);
    int          dd = (dw == 8'd0) ? 1 : int'(dw);
    logic [31:0] next_count = (d == 1'b0) ? model_count + 32'd1 : model_count - 32'd1;
    logic [1:0]  ab;
    seq_base = model_count;
    for (int p = 1; p <= 3; p++) begin
      ab = d ? enter_seq[4-p] : enter_seq[p];
      for (int i = 0; i < dd; i++) trace_q.push_back(mk(ab, 2'(p), 1'b0, 1'b0, model_count));
    end
    for (int i = 0; i < GAP_CYC; i++) trace_q.push_back(mk(2'b00, 2'd0, 1'b0, 1'b0, model_count));
    trace_q.push_back(mk(2'b00, 2'd0, 1'b1, 1'b1, next_count));
    done_q.push_back(next_count);
    model_count = next_count;
  endfunction

  // A backed-out car leaves a full clear gap and no completion.
  function automatic void abort_sequence();
    trace_q.delete();
    for (int i = 0; i < GAP_CYC; i++) trace_q.push_back(mk(2'b00, 2'd0, 1'b0, 1'b0, seq_base));
    trace_q.push_back(mk(2'b00, 2'd0, 1'b1, 1'b0, seq_base));
    void'(done_q.pop_back());
    model_count = seq_base;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (trace_q.size() > 0) e = trace_q.pop_front();
      else                    e = mk(2'b00, 2'd0, 1'b1, 1'b0, model_count);
      cur_phase = e.phase;
      checkOutput("beams", 32'({a, b}), 32'({e.a, e.b}));
      checkOutput("phase", 32'(phase), 32'(e.phase));
      checkOutput("ready", 32'(ready), 32'(e.ready));
      checkOutput("done", 32'(done), 32'(e.done));
      checkOutput("net_count", net_count, e.count);
      if (done) begin
        if (done_q.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL done_event actual=pulse required=none at %0t", $time);
        end else begin
          checkOutput("done_event_count", net_count, done_q.pop_front());
        end
      end
    end
  end

  task automatic applyStimulus(input logic s, input logic d, input logic [7:0] dw, input logic ab);
    @(negedge clk);
    #1;
    start = s; dir = d; dwell = dw; abort = ab;
    if (s && trace_q.size() == 0) push_sequence(d, dw);
    else if (ab && cur_phase != 2'd0) abort_sequence();
  endtask

  task automatic waitIdle();
    int n = 0;
    while (trace_q.size() > 0 && n < 200) begin
      applyStimulus(1'b0, 1'b0, 8'd0, 1'b0);
      n++;
    end
    if (trace_q.size() > 0) begin
      total++;
      bad++;
      $display("[TB] FAIL wait_idle actual=%0d pending required=0 at %0t", trace_q.size(), $time);
    end
    applyStimulus(1'b0, 1'b0, 8'd0, 1'b0);
  endtask

  // Reset dropped in the low half of the clock so no edge can mask its effect.
  task automatic asyncReset();
    @(negedge clk);
    #3;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    checkOutput("rst_a", 32'(a), 32'd0);
    checkOutput("rst_b", 32'(b), 32'd0);
    checkOutput("rst_ready", 32'(ready), 32'd1);
    checkOutput("rst_phase", 32'(phase), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_count", net_count, 32'd0);
    trace_q.delete();
    done_q.delete();
    model_count = '0;
    seq_base    = '0;
    cur_phase   = '0;
    @(negedge clk);
    #1;
    start  = 1'b0;
    abort  = 1'b0;
    rst_n  = 1'b1;
    mon_en = 1'b1;
  endtask

  initial begin
    int n;
    #12;
    checkOutput("por_ready", 32'(ready), 32'd1);
    checkOutput("por_beams", 32'({a, b}), 32'd0);
    checkOutput("por_phase", 32'(phase), 32'd0);
    checkOutput("por_count", net_count, 32'd0);
    @(negedge clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;

    applyStimulus(1'b1, 1'b0, 8'd3, 1'b0);
    waitIdle();
    applyStimulus(1'b1, 1'b1, 8'd0, 1'b0);
    waitIdle();

    asyncReset();
    applyStimulus(1'b1, 1'b1, 8'd1, 1'b0);
    waitIdle();
    applyStimulus(1'b1, 1'b0, 8'd1, 1'b0);
    waitIdle();

    applyStimulus(1'b1, 1'b0, 8'd4, 1'b0);
    repeat (5) applyStimulus(1'b0, 1'b1, 8'd7, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'd0, 1'b1);
    waitIdle();

    repeat (40) applyStimulus(1'b1, 1'b0, 8'd2, 1'b0);
    waitIdle();

    applyStimulus(1'b1, 1'b0, 8'd4, 1'b0);
    n = 0;
    while (cur_phase != 2'd2 && n < 20) begin
      applyStimulus(1'b0, 1'b0, 8'd0, 1'b0);
      n++;
    end
    asyncReset();

    repeat (1500)
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    8'($urandom_range(0, 5)), ($urandom_range(0, 19) == 0));
    waitIdle();
    checkOutput("done_q_drained", 32'(done_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=timeout required=finish at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/park_gate_driver.md
Name: park_gate_driver

Overview:
- Sensor-side emulator for the two-beam parking-gate protocol: drives beam lines `a`/`b` with the exact sequence a car produces when entering or exiting.
- The sequence is accepted by the gate FSM that decodes enter/exit events.
- Sits in front of the gate FSM/occupancy counter pair as the transmitter end of the sensor interface; used for self-test and system-level stimulus.
- Keeps a net car count mirroring what the downstream counter must report.

Parameters:
- DWELL_W, 8, width of the per-phase dwell-length input.
- GAP_CYC, 2, cycles of both-beams-clear held after each sequence (≥1).
- CNT_W, 32, width of `net_count`.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request a car sequence; accepted only on an edge where `ready`=1.
- dir  in  1  sampled with `start`: 0 = enter, 1 = exit.
- dwell  in  DWELL_W  cycles per beam phase, sampled with `start`; 0 is treated as 1.
- abort  in  1  cancel the in-flight sequence (car backs out).
- ready  out  1  idle, can accept `start`.
- done  out  1  one-cycle pulse on completion of a non-aborted sequence.
- a  out  1  beam A (outer) blocked.
- b  out  1  beam B (inner) blocked.
- phase  out  2  current phase: 0 idle/gap, 1 first beam, 2 both, 3 second beam.
- net_count  out  CNT_W  +1 per completed enter, −1 per completed exit.

Behaviour:
- All outputs are registered.
- Reset values: `ready`=1, `done`=0, `a`=0, `b`=0, `phase`=0, `net_count`=0, state IDLE.
- Reset asserted mid-sequence returns everything to reset values immediately; `net_count` is not updated.
- States: IDLE, P1, P2, P3, GAP.
- Beam values by direction:
  - Enter: P1 a=1 b=0; P2 a=1 b=1; P3 a=0 b=1.
  - Exit: P1 a=0 b=1; P2 a=1 b=1; P3 a=1 b=0.
  - GAP and IDLE: a=b=0.
- Timing, with `start` accepted at edge k and D = max(dwell,1):
  - Cycles k+1..k+D: P1.
  - Cycles k+D+1..k+2D: P2.
  - Cycles k+2D+1..k+3D: P3.
  - Cycles k+3D+1..k+3D+GAP_CYC: GAP.
  - Cycle k+3D+GAP_CYC+1: IDLE with `done`=1 and `ready`=1.
- `dir` and D are latched at acceptance; changes to them mid-sequence have no effect.
- `ready` drops in the cycle after acceptance and stays 0 through GAP.
- `start` while `ready`=0 is ignored, not queued.
- A `start` in the same cycle as `done` is accepted (back-to-back sequences, minimum GAP_CYC clear cycles between them).
- `net_count` updates in the same cycle `done` asserts and wraps modulo 2^CNT_W in both directions.
- `abort` sampled high in P1/P2/P3:
  - Next cycle is the first GAP cycle, a=b=0, with a full GAP_CYC count.
  - No `done` pulse; `net_count` unchanged.
  - On leaving GAP, returns to IDLE with `ready`=1.
- `abort` in IDLE or GAP has no effect.
- `abort` and `start` together in IDLE: `start` is accepted and `abort` ignored.
- Phase dwell uses a down-counter loaded with D−1 on each phase entry; the phase advances when the count is 0.
- GAP uses the same counter loaded with GAP_CYC−1.
- At most one beam changes per cycle boundary (Gray-coded beam sequence); no glitch states such as a=1 b=0 between P2 and P3 on an exit.

Decomposition:
- Shared package `park_pkg`:
  - state enum {IDLE,P1,P2,P3,GAP}.
  - Phase codes PH_IDLE=0, PH_FIRST=1, PH_BOTH=2, PH_SECOND=3.
  - Direction constants DIR_ENTER=0, DIR_EXIT=1.
  - Beam-pattern function (dir, phase) → {a,b}, reused by the gate FSM checker.
- One sub-module: `dwell_timer`, a loadable DWELL_W-bit down-counter with load, enable and a zero flag.

Test Plan:
- Reset, then start dir=0 dwell=3 → {a,b} = 10×3, 11×3, 01×3, 00×2; `done` pulse at cycle 12 after acceptance; `net_count`=1; the gate FSM's `enter` pulses once.
- After that, start dir=1 dwell=0 → {a,b} = 01, 11, 10, one cycle each, then gap; `done` at cycle 6; `net_count`=0; the gate FSM's `exit` pulses once.
- From reset, start dir=1 dwell=1 → `net_count` wraps to 0xFFFFFFFF; then an enter returns it to 0.
- Start dir=0 dwell=4, `abort` during the 2nd P2 cycle → a=b=0 on the next cycle; GAP lasts 2 cycles; no `done`; `net_count` unchanged; `ready`=1 afterwards.
- `start` held high continuously with dir=0 dwell=2 → back-to-back sequences exactly 9 cycles apart; extra `start` pulses while `ready`=0 are ignored.
- Deassert `rst_n` asynchronously mid-P2 → a=b=0, `ready`=1, `phase`=0, `net_count`=0 immediately, without waiting for a clock edge.
